// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to the device over the
// open-drain PS/2 clock/data pair. Lines are only ever pulled low (o_*_oe = 1);
// the pads tri-state otherwise.
//
// Ports
//   i_clk            system clock
//   i_rst            asynchronous reset, active high
//   i_tx_data[7:0]   command byte, sampled when the request is accepted
//   i_tx_valid       request; accepted when i_tx_valid & o_tx_ready
//   o_tx_ready       high only while idle
//   o_tx_done        1-cycle pulse: byte sent and device ACK seen
//   o_tx_err         1-cycle pulse: NACK, or watchdog expiry when enabled
//   i_ps2_clk_in     raw PS/2 clock line (asynchronous)
//   i_ps2_data_in    raw PS/2 data line (asynchronous)
//   o_ps2_clk_oe     1 = pull PS/2 clock low
//   o_ps2_data_oe    1 = pull PS/2 data low
//
// Build option
//   PS2_TX_TIMEOUT_EN  when defined, a watchdog aborts a frame that has not finished
//                      within TIMEOUT_CYC cycles after the inhibit phase. Without it a
//                      silent device leaves the transmitter waiting in XFER.
//
// States
//   IDLE     | lines released, ready for a byte
//   INHIBIT  | clock held low for the inhibit time
//   START    | clock still low, data low (start bit), one cycle
//   XFER     | device clocks; next bit driven after each falling edge
//   ACK      | waiting for fall 11 to sample the device ACK
//   WAITIDLE | waiting for both lines high before reporting done

module ps2_host_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 120,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_done,
    output logic       o_tx_err,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int CNT_W       = $clog2(INHIBIT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_XFER, S_ACK, S_WAITIDLE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_clk_sync, r_data_sync;
    logic             r_clk_prev;
    logic             w_clk_s, w_data_s, w_fall;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_bitcnt, w_bitcnt_nxt;
    logic [9:0]       r_shift, w_shift_nxt;
    logic             r_clk_oe, w_clk_oe_nxt;
    logic             r_data_oe, w_data_oe_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic             w_wd_expired;

    // Lines idle high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk_in};
            r_data_sync <= {r_data_sync[0], i_ps2_data_in};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wdog;

    // Saturates at the limit; cleared on the next accepted byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wdog <= '0;
        end else if (r_state == S_IDLE && i_tx_valid) begin
            r_wdog <= '0;
        end else if (r_state != S_IDLE && r_state != S_INHIBIT &&
                     r_wdog != WD_W'(TIMEOUT_CYC)) begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    assign w_wd_expired = (r_wdog == WD_W'(TIMEOUT_CYC));
`else
    // Watchdog compiled out; the compare is constant false.
    assign w_wd_expired = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_clk_oe_nxt  = r_clk_oe;
        w_data_oe_nxt = r_data_oe;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_bitcnt_nxt  = '0;
                if (i_tx_valid) begin
                    w_shift_nxt  = {1'b1, ~^i_tx_data, i_tx_data};
                    w_cnt_nxt    = CNT_W'(INHIBIT_CYC - 1);
                    w_clk_oe_nxt = 1'b1;
                    w_state_nxt  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_cnt == '0) begin
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = S_START;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_START: begin
                w_clk_oe_nxt = 1'b0;
                w_state_nxt  = S_XFER;
            end
            S_XFER: begin
                // Stop bit in r_shift[9] is 1, so bit 9 releases the data line.
                if (w_fall) begin
                    w_data_oe_nxt = ~r_shift[r_bitcnt];
                    w_bitcnt_nxt  = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd9) begin
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    if (w_data_s) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAITIDLE;
                    end
                end
            end
            S_WAITIDLE: begin
                if (w_clk_s && w_data_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_wd_expired &&
            (r_state == S_XFER || r_state == S_ACK || r_state == S_WAITIDLE)) begin
            w_state_nxt   = S_IDLE;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_done_nxt    = 1'b0;
            w_err_nxt     = 1'b1;
        end
    end

    assign o_tx_ready    = (r_state == S_IDLE);
    assign o_tx_done     = r_done;
    assign o_tx_err      = r_err;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;

endmodule
